branch_predictor: RTL and testbench

- Direct-mapped, tagged branch history table with 2-bit saturating counters.
- Sits beside the FD stage. It supplies pred_taken to the pipeline control logic for the conditional branch currently in FD.
- It is trained from the X stage with the resolved outcome (br_taken) and the mispredict flag produced by control logic.
- It also keeps saturating branch and mispredict counters for CSR/perf readout.

---
 rtl/branch_predictor.sv | 111 +++++++++++
 tb/tb_branch_predictor.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped tagged branch history table with 2-bit saturating counters and perf counters.
// Optional macro BRANCH_BYPASS_EN forwards a same-cycle update to the lookup path.
module branch_predictor #(
  parameter int PC_WIDTH = 32,
  parameter int LINES    = 8,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PC_WIDTH-1:0] pc_fd,
  input  logic                fd_is_branch,
  output logic                pred_taken,
  input  logic [PC_WIDTH-1:0] pc_x,
  input  logic                x_is_branch,
  input  logic                br_taken,
  input  logic                mispredict,
  input  logic                stall,
  output logic [CNT_W-1:0]    br_count,
  output logic [CNT_W-1:0]    mispred_count
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = PC_WIDTH - 2 - IDX_W;

  logic [LINES-1:0] valid_reg;
  logic [TAG_W-1:0] tag_reg [LINES];
  logic [1:0]       ctr_reg [LINES];

  logic [IDX_W-1:0] idx_fd;
  logic [IDX_W-1:0] idx_x;
  logic [TAG_W-1:0] tag_fd;
  logic [TAG_W-1:0] tag_x;
  logic             upd;
  logic             hit_x;
  logic [1:0]       ctr_cur;
  logic [1:0]       ctr_next;
  logic             look_valid;
  logic [TAG_W-1:0] look_tag;
  logic [1:0]       look_ctr;
  logic             unused_pc_bits;

  assign idx_fd = pc_fd[2 +: IDX_W];
  assign tag_fd = pc_fd[PC_WIDTH-1 : 2+IDX_W];
  assign idx_x  = pc_x[2 +: IDX_W];
  assign tag_x  = pc_x[PC_WIDTH-1 : 2+IDX_W];
  assign unused_pc_bits = ^{pc_fd[1:0], pc_x[1:0]};

  assign upd     = x_is_branch & ~stall;
  assign ctr_cur = ctr_reg[idx_x];
  assign hit_x   = valid_reg[idx_x] && (tag_reg[idx_x] == tag_x);

  // Hits move the counter one step; misses allocate in the weak state of the outcome.
  always_comb begin
    ctr_next = ctr_cur;
    if (hit_x) begin
      if (br_taken) begin
        ctr_next = (ctr_cur == 2'b11) ? 2'b11 : ctr_cur + 2'd1;
      end else begin
        ctr_next = (ctr_cur == 2'b00) ? 2'b00 : ctr_cur - 2'd1;
      end
    end else begin
      ctr_next = br_taken ? 2'b10 : 2'b01;
    end
  end

  generate
    for (genvar gi = 0; gi < LINES; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_reg[gi] <= 1'b0;
          tag_reg[gi]   <= '0;
          ctr_reg[gi]   <= 2'b00;
        end else if (upd && (idx_x == IDX_W'(gi))) begin
          valid_reg[gi] <= 1'b1;
          tag_reg[gi]   <= tag_x;
          ctr_reg[gi]   <= ctr_next;
        end
      end
    end
  endgenerate

`ifdef BRANCH_BYPASS_EN
  logic bypass;
  assign bypass     = upd && (idx_x == idx_fd);
  assign look_valid = bypass ? 1'b1     : valid_reg[idx_fd];
  assign look_tag   = bypass ? tag_x    : tag_reg[idx_fd];
  assign look_ctr   = bypass ? ctr_next : ctr_reg[idx_fd];
`else
  assign look_valid = valid_reg[idx_fd];
  assign look_tag   = tag_reg[idx_fd];
  assign look_ctr   = ctr_reg[idx_fd];
`endif

  assign pred_taken = fd_is_branch & look_valid & (look_tag == tag_fd) & look_ctr[1];

  // Perf counters stop at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else if (upd) begin
      if (br_count != {CNT_W{1'b1}}) begin
        br_count <= br_count + CNT_W'(1);
      end
      if (mispredict && (mispred_count != {CNT_W{1'b1}})) begin
        mispred_count <= mispred_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: table-driven train/lookup vectors plus
// hand-written sequences for bypass, stall, counter saturation and async reset.
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_fd;
  logic        fd_is_branch;
  logic        pred_taken;
  logic [31:0] pc_x;
  logic        x_is_branch;
  logic        br_taken;
  logic        mispredict;
  logic        stall;
  logic [31:0] br_count;
  logic [31:0] mispred_count;
  logic        pred_taken4;
  logic [3:0]  br_count4;
  logic [3:0]  mispred_count4;

  int checks;
  int failures;

  branch_predictor #(.PC_WIDTH(32), .LINES(8), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .pc_fd(pc_fd), .fd_is_branch(fd_is_branch),
    .pred_taken(pred_taken), .pc_x(pc_x), .x_is_branch(x_is_branch),
    .br_taken(br_taken), .mispredict(mispredict), .stall(stall),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  branch_predictor #(.PC_WIDTH(32), .LINES(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .pc_fd(pc_fd), .fd_is_branch(fd_is_branch),
    .pred_taken(pred_taken4), .pc_x(pc_x), .x_is_branch(x_is_branch),
    .br_taken(br_taken), .mispredict(mispredict), .stall(stall),
    .br_count(br_count4), .mispred_count(mispred_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_train;
    logic [31:0] pc;
    bit          taken;
    bit          fdb;
    bit          exp;
  } vec_t;

  vec_t vecs[40];
  int   nv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h (t=%0t)", name, act, $time);
    end
  endtask

  task automatic add(input bit is_train, input logic [31:0] pc, input bit taken,
                     input bit fdb, input bit exp);
    vecs[nv].is_train = is_train;
    vecs[nv].pc       = pc;
    vecs[nv].taken    = taken;
    vecs[nv].fdb      = fdb;
    vecs[nv].exp      = exp;
    nv++;
  endtask

  task automatic train(input logic [31:0] pc, input bit taken, input bit mis);
    pc_x        = pc;
    x_is_branch = 1'b1;
    br_taken    = taken;
    mispredict  = mis;
    @(posedge clk);
    #1;
    x_is_branch = 1'b0;
    mispredict  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    checks = 0; failures = 0; nv = 0;
    rst_n = 1'b0; pc_fd = '0; fd_is_branch = 1'b0; pc_x = '0;
    x_is_branch = 1'b0; br_taken = 1'b0; mispredict = 1'b0; stall = 1'b0;

    // allocation / hysteresis
    add(0, 32'h100, 0, 1, 0);
    add(1, 32'h100, 1, 0, 0);
    add(0, 32'h100, 0, 1, 1);
    add(1, 32'h100, 0, 0, 0);
    add(0, 32'h100, 0, 1, 0);
    add(1, 32'h100, 1, 0, 0);
    add(0, 32'h100, 0, 0, 0);
    add(0, 32'h100, 0, 1, 1);
    // saturation on 0x104
    for (int i = 0; i < 5; i++) add(1, 32'h104, 1, 0, 0);
    add(0, 32'h104, 0, 1, 1);
    add(1, 32'h104, 0, 0, 0);
    add(0, 32'h104, 0, 1, 1);
    add(1, 32'h104, 0, 0, 0);
    add(0, 32'h104, 0, 1, 0);
    // aliasing: 0x100 and 0x120 share index 0
    add(1, 32'h100, 1, 0, 0);
    add(0, 32'h120, 0, 1, 0);
    add(0, 32'h100, 0, 1, 1);
    add(1, 32'h120, 0, 0, 0);
    add(0, 32'h100, 0, 1, 0);
    add(1, 32'h120, 1, 0, 0);
    add(0, 32'h120, 0, 1, 1);
    add(0, 32'h123, 0, 1, 1);
    add(0, 32'h100, 0, 1, 0);

    #2;
    check("reset_pred", {31'b0, pred_taken}, 32'd0);
    do_reset();
    pc_fd = 32'h100; fd_is_branch = 1'b1; #1;
    check("post_reset_pred", {31'b0, pred_taken}, 32'd0);
    check("post_reset_br_count", br_count, 32'd0);
    check("post_reset_mispred_count", mispred_count, 32'd0);

    for (int i = 0; i < nv; i++) begin
      if (vecs[i].is_train) begin
        fd_is_branch = 1'b0;
        train(vecs[i].pc, vecs[i].taken, 1'b0);
      end else begin
        pc_fd = vecs[i].pc; fd_is_branch = vecs[i].fdb; #1;
        check($sformatf("vec%0d_lookup_0x%0h", i, vecs[i].pc), {31'b0, pred_taken},
              {31'b0, vecs[i].exp});
      end
    end
    check("table_br_count", br_count, 32'd13);
    check("table_mispred_count", mispred_count, 32'd0);

    // same-cycle lookup and update on a fresh table
    do_reset();
    pc_fd = 32'h108; fd_is_branch = 1'b1;
    pc_x = 32'h108; x_is_branch = 1'b1; br_taken = 1'b1; #1;
`ifdef BRANCH_BYPASS_EN
    check("bypass_same_cycle", {31'b0, pred_taken}, 32'd1);
`else
    check("bypass_same_cycle", {31'b0, pred_taken}, 32'd0);
`endif
    @(posedge clk); #1;
    x_is_branch = 1'b0; #1;
    check("bypass_next_cycle", {31'b0, pred_taken}, 32'd1);

    // stall blocks training and counting
    do_reset();
    pc_fd = 32'h108; fd_is_branch = 1'b1;
    pc_x = 32'h108; x_is_branch = 1'b1; br_taken = 1'b1; mispredict = 1'b1; stall = 1'b1; #1;
    check("stall_same_cycle", {31'b0, pred_taken}, 32'd0);
    @(posedge clk); #1;
    check("stall_after_edge", {31'b0, pred_taken}, 32'd0);
    check("stall_br_count", br_count, 32'd0);
    check("stall_mispred_count", mispred_count, 32'd0);
    stall = 1'b0; x_is_branch = 1'b0; mispredict = 1'b0;

    // 5 edges, 2 mispredicted; mispredict without a branch is ignored
    do_reset();
    fd_is_branch = 1'b0;
    train(32'h200, 1, 1);
    train(32'h204, 0, 0);
    train(32'h208, 1, 1);
    train(32'h20c, 0, 0);
    train(32'h210, 1, 0);
    mispredict = 1'b1;
    @(posedge clk); #1;
    mispredict = 1'b0;
    check("perf_br_count", br_count, 32'd5);
    check("perf_mispred_count", mispred_count, 32'd2);

    // narrow counters saturate
    do_reset();
    for (int i = 0; i < 20; i++) train(32'h108, 1, 1);
    check("sat_br_count4", {28'b0, br_count4}, 32'd15);
    check("sat_mispred_count4", {28'b0, mispred_count4}, 32'd15);
    check("wide_br_count", br_count, 32'd20);
    check("wide_mispred_count", mispred_count, 32'd20);
    train(32'h108, 1, 1);
    check("sat_hold_br_count4", {28'b0, br_count4}, 32'd15);
    check("sat_hold_mispred_count4", {28'b0, mispred_count4}, 32'd15);

    // asynchronous reset mid-stream
    pc_fd = 32'h108; fd_is_branch = 1'b1;
    pc_x = 32'h108; x_is_branch = 1'b1; br_taken = 1'b1; mispredict = 1'b1; #1;
    check("pre_async_pred", {31'b0, pred_taken}, 32'd1);
    rst_n = 1'b0; #1;
    check("async_br_count", br_count, 32'd0);
    check("async_mispred_count", mispred_count, 32'd0);
    check("async_pred", {31'b0, pred_taken}, 32'd0);
    @(posedge clk); #1;
    check("in_reset_br_count", br_count, 32'd0);
    check("in_reset_pred", {31'b0, pred_taken}, 32'd0);
    x_is_branch = 1'b0; mispredict = 1'b0;
    rst_n = 1'b1; #1;
    check("release_pred", {31'b0, pred_taken}, 32'd0);
    check("release_br_count4", {28'b0, br_count4}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
